// File: rtl/operand_fetch_seq_pkg.sv
// Shared types and constants for the operand fetch sequencer (package opfetch_pkg).
// Optional immediate operand path is enabled with OPFETCH_IMM_EN.
package opfetch_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] X0_ADDR = 5'd0;

    localparam logic RF_LOAD  = 1'b1;
    localparam logic RF_STORE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        RS1,
        RS2,
        CAP,
        HOLD
    } state_t;

    // Which requester owns the shared register-file port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RS1,
        SEL_RS2,
        SEL_WB
    } port_sel_t;

    function automatic logic is_x0(input logic [REG_AW-1:0] addr);
        return addr == X0_ADDR;
    endfunction

endpackage

// File: rtl/operand_fetch_seq_if.sv
// Bus bundle of the operand fetch sequencer: decode, writeback, register-file port, execute.
// master = the sequencer, slave = its surroundings; OPFETCH_IMM_EN adds the immediate inputs.
interface operand_fetch_seq_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) ();
    import opfetch_pkg::*;

    logic              dec_valid;
    logic              dec_ready;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic [CTRL_W-1:0] dec_ctrl;
`ifdef OPFETCH_IMM_EN
    logic              dec_use_imm;
    logic [XLEN-1:0]   dec_imm;
`endif

    logic              wb_valid;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;

    logic              rf_ld_str;
    logic [REG_AW-1:0] rf_addr;
    logic [XLEN-1:0]   rf_wdata;
    logic [XLEN-1:0]   rf_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_op_a;
    logic [XLEN-1:0]   out_op_b;
    logic [REG_AW-1:0] out_rd;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_ctrl,
`ifdef OPFETCH_IMM_EN
        input  dec_use_imm, dec_imm,
`endif
        output dec_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output rf_ld_str, rf_addr, rf_wdata,
        input  rf_rdata,
        output out_valid, out_op_a, out_op_b, out_rd, out_ctrl,
        input  out_ready
    );

    modport slave (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_ctrl,
`ifdef OPFETCH_IMM_EN
        output dec_use_imm, dec_imm,
`endif
        input  dec_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  rf_ld_str, rf_addr, rf_wdata,
        output rf_rdata,
        input  out_valid, out_op_a, out_op_b, out_rd, out_ctrl,
        output out_ready
    );

endinterface

// File: rtl/operand_fetch_seq_ctrl.sv
// Control FSM of the operand fetch sequencer (module opfetch_ctrl): state, handshake
// readies, capture strobes and the shared register-file port select.
module opfetch_ctrl
    import opfetch_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      dec_valid,
    input  logic      wb_valid,
    input  logic      wb_is_x0,
    input  logic      use_imm,
    input  logic      out_ready,
    output logic      dec_ready,
    output logic      wb_ready,
    output logic      dec_fire,
    output logic      wb_fire,
    output logic      out_valid,
    output logic      capture_a,
    output logic      capture_b,
    output port_sel_t sel
);

    state_t state;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_ready = (state == IDLE) && !wb_valid && !reset;
        wb_ready  = ((state == IDLE) || (state == HOLD)) && !reset;
        dec_fire  = dec_valid && dec_ready;
        wb_fire   = wb_valid && wb_ready;
        capture_a = (state == RS2) || ((state == CAP) && use_imm);
        capture_b = (state == CAP);
        sel       = SEL_NONE;
        unique case (state)
            RS1:        sel = SEL_RS1;
            RS2:        sel = SEL_RS2;
            IDLE, HOLD: if (wb_fire && !wb_is_x0) sel = SEL_WB;
            default:    sel = SEL_NONE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (dec_fire) state <= RS1;
                RS1:  state <= use_imm ? CAP : RS2;
                RS2:  state <= CAP;
                CAP: begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end
                HOLD: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: reads rs1/rs2 through one shared register-file port and
// arbitrates writeback into it. Define OPFETCH_IMM_EN to allow an immediate op_b.
module operand_fetch_seq
    import opfetch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input logic                 clk,
    input logic                 reset,
    operand_fetch_seq_if.master bus
);

    logic              dec_fire;
    logic              wb_fire;
    logic              out_valid;
    logic              capture_a;
    logic              capture_b;
    port_sel_t         sel;
    logic              use_imm_q;

    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [XLEN-1:0]   op_a_q;
    logic [XLEN-1:0]   op_b_q;
    logic [REG_AW-1:0] rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   b_src;

    opfetch_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .dec_valid (bus.dec_valid),
        .wb_valid  (bus.wb_valid),
        .wb_is_x0  (is_x0(bus.wb_addr)),
        .use_imm   (use_imm_q),
        .out_ready (bus.out_ready),
        .dec_ready (bus.dec_ready),
        .wb_ready  (bus.wb_ready),
        .dec_fire  (dec_fire),
        .wb_fire   (wb_fire),
        .out_valid (out_valid),
        .capture_a (capture_a),
        .capture_b (capture_b),
        .sel       (sel)
    );

`ifdef OPFETCH_IMM_EN
    logic [XLEN-1:0] imm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            use_imm_q <= 1'b0;
            imm_q     <= '0;
        end else if (dec_fire) begin
            use_imm_q <= bus.dec_use_imm;
            imm_q     <= bus.dec_imm;
        end
    end

    assign b_src = use_imm_q ? imm_q : (is_x0(rs2_q) ? '0 : bus.rf_rdata);
`else
    assign use_imm_q = 1'b0;
    assign b_src     = is_x0(rs2_q) ? '0 : bus.rf_rdata;
`endif

    // Captures read the port one cycle after the address was driven (registered file).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_q  <= X0_ADDR;
            rs2_q  <= X0_ADDR;
            rd_q   <= X0_ADDR;
            ctrl_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            if (dec_fire) begin
                rs1_q  <= bus.dec_rs1;
                rs2_q  <= bus.dec_rs2;
                rd_q   <= bus.dec_rd;
                ctrl_q <= bus.dec_ctrl;
            end
            if (capture_a) op_a_q <= is_x0(rs1_q) ? '0 : bus.rf_rdata;
            if (capture_b) op_b_q <= b_src;
        end
    end

    // A write only reaches the port when it was handshaken and targets a real register.
    always_comb begin
        bus.rf_ld_str = RF_LOAD;
        bus.rf_addr   = X0_ADDR;
        bus.rf_wdata  = '0;
        unique case (sel)
            SEL_RS1: bus.rf_addr = rs1_q;
            SEL_RS2: bus.rf_addr = rs2_q;
            SEL_WB: begin
                bus.rf_ld_str = RF_STORE;
                bus.rf_addr   = bus.wb_addr;
                bus.rf_wdata  = bus.wb_data;
            end
            default: bus.rf_addr = X0_ADDR;
        endcase
    end

    assign bus.out_valid = out_valid;
    assign bus.out_op_a  = op_a_q;
    assign bus.out_op_b  = op_b_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_ctrl  = ctrl_q;

    logic unused_wb_fire;
    assign unused_wb_fire = wb_fire;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Directed bench for operand_fetch_seq with a registered single-port register-file model.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_operand_fetch_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_seq_if #(.XLEN(32), .CTRL_W(8)) bus ();

    operand_fetch_seq #(.XLEN(32), .CTRL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] rf_mem [32];

    always @(posedge clk) begin
        if (bus.rf_ld_str == 1'b0) rf_mem[bus.rf_addr] <= bus.rf_wdata;
        bus.rf_rdata <= rf_mem[bus.rf_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic issue_decode(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [7:0] ctrl);
        bus.dec_valid = 1'b1;
        bus.dec_rs1   = rs1;
        bus.dec_rs2   = rs2;
        bus.dec_rd    = rd;
        bus.dec_ctrl  = ctrl;
        #1;
        checks++;
        if (bus.dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL dec_ready_accept: got %b want 1", bus.dec_ready);
        end
        @(negedge clk);
        bus.dec_valid = 1'b0;
    endtask

    task automatic issue_write(input logic [4:0] addr, input logic [31:0] data,
                               input logic exp_ld_str);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = addr;
        bus.wb_data  = data;
        #1;
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.rf_ld_str !== exp_ld_str) begin
            errors++;
            $display("FAIL write_port x%0d: wb_ready=%b ld_str=%b want 1/%b",
                     addr, bus.wb_ready, bus.rf_ld_str, exp_ld_str);
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_valid_drop: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic check_ops(input string name, input int lat, input int exp_lat,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (bus.out_op_a !== a || bus.out_op_b !== b || bus.out_rd !== rd) begin
            errors++;
            $display("FAIL %s_operands: got a=%h b=%h rd=%0d want a=%h b=%h rd=%0d",
                     name, bus.out_op_a, bus.out_op_b, bus.out_rd, a, b, rd);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.dec_valid = 1'b0;
        bus.dec_rs1   = '0;
        bus.dec_rs2   = '0;
        bus.dec_rd    = '0;
        bus.dec_ctrl  = '0;
`ifdef OPFETCH_IMM_EN
        bus.dec_use_imm = 1'b0;
        bus.dec_imm     = '0;
`endif
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd4;
        bus.wb_data   = 32'h1234;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.dec_ready !== 1'b0 || bus.wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: valid=%b dec_ready=%b wb_ready=%b want 0/0/0",
                     bus.out_valid, bus.dec_ready, bus.wb_ready);
        end
        checks++;
        if (bus.rf_ld_str !== 1'b1 || bus.rf_addr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_port: ld_str=%b addr=%0d wdata=%h want 1/0/0",
                     bus.rf_ld_str, bus.rf_addr, bus.rf_wdata);
        end
        checks++;
        if ({bus.out_op_a, bus.out_op_b, bus.out_rd, bus.out_ctrl} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h rd=%0d ctrl=%h want all 0",
                     bus.out_op_a, bus.out_op_b, bus.out_rd, bus.out_ctrl);
        end
        bus.wb_valid = 1'b0;
        reset        = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        issue_write(5'd3, 32'h11, 1'b0);
        issue_write(5'd7, 32'h22, 1'b0);
        issue_write(5'd5, 32'hABCD, 1'b0);
        issue_decode(5'd3, 5'd7, 5'd9, 8'h5A);
        checks++;
        if (bus.rf_addr !== 5'd3 || bus.rf_ld_str !== 1'b1) begin
            errors++;
            $display("FAIL basic_rs1_addr: got addr=%0d ld_str=%b want 3/1", bus.rf_addr, bus.rf_ld_str);
        end
        wait_out(lat);
        check_ops("basic", lat, 3, 32'h11, 32'h22, 5'd9);
        checks++;
        if (bus.out_ctrl !== 8'h5A) begin
            errors++;
            $display("FAIL basic_ctrl: got %h want 5a", bus.out_ctrl);
        end
        accept_out();
    endtask

    task automatic test_x0();
        int lat;
        issue_decode(5'd0, 5'd5, 5'd6, 8'h01);
        wait_out(lat);
        check_ops("x0_rs1", lat, 3, 32'h0, 32'hABCD, 5'd6);
        accept_out();
        issue_write(5'd0, 32'hFFFF, 1'b1);
        checks++;
        if (rf_mem[0] !== 32'hDEAD) begin
            errors++;
            $display("FAIL x0_write_dropped: x0 holds %h want dead", rf_mem[0]);
        end
        issue_decode(5'd0, 5'd0, 5'd1, 8'h02);
        wait_out(lat);
        check_ops("x0_both", lat, 3, 32'h0, 32'h0, 5'd1);
        accept_out();
    endtask

    task automatic test_wb_priority();
        int lat;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd7;
        bus.wb_data   = 32'h77;
        bus.dec_valid = 1'b1;
        bus.dec_rs1   = 5'd7;
        bus.dec_rs2   = 5'd3;
        bus.dec_rd    = 5'd1;
        bus.dec_ctrl  = 8'h10;
        #1;
        checks++;
        if (bus.dec_ready !== 1'b0 || bus.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_readies: dec_ready=%b wb_ready=%b want 0/1", bus.dec_ready, bus.wb_ready);
        end
        checks++;
        if (bus.rf_ld_str !== 1'b0 || bus.rf_addr !== 5'd7 || bus.rf_wdata !== 32'h77) begin
            errors++;
            $display("FAIL prio_store: ld_str=%b addr=%0d wdata=%h want 0/7/77",
                     bus.rf_ld_str, bus.rf_addr, bus.rf_wdata);
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_dec_next: dec_ready=%b want 1", bus.dec_ready);
        end
        @(negedge clk);
        bus.dec_valid = 1'b0;
        wait_out(lat);
        check_ops("prio", lat, 3, 32'h77, 32'h11, 5'd1);
        accept_out();
    endtask

    task automatic test_hold_wb();
        int lat;
        issue_decode(5'd3, 5'd7, 5'd2, 8'h20);
        wait_out(lat);
        check_ops("hold", lat, 3, 32'h11, 32'h77, 5'd2);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                bus.wb_valid = 1'b1;
                bus.wb_addr  = 5'd3;
                bus.wb_data  = 32'h99;
                #1;
                checks++;
                if (bus.wb_ready !== 1'b1 || bus.rf_ld_str !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_write: wb_ready=%b ld_str=%b want 1/0", bus.wb_ready, bus.rf_ld_str);
                end
            end
            @(negedge clk);
            bus.wb_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_op_a !== 32'h11 || bus.out_op_b !== 32'h77) begin
                errors++;
                $display("FAIL hold_stable_%0d: valid=%b a=%h b=%h want 1/11/77",
                         i, bus.out_valid, bus.out_op_a, bus.out_op_b);
            end
        end
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd8;
        bus.wb_data   = 32'h88;
        #1;
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.rf_ld_str !== 1'b0) begin
            errors++;
            $display("FAIL hold_dual: wb_ready=%b ld_str=%b want 1/0", bus.wb_ready, bus.rf_ld_str);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_dual_done: out_valid=%b want 0", bus.out_valid);
        end
        issue_decode(5'd3, 5'd8, 5'd2, 8'h21);
        wait_out(lat);
        check_ops("reread", lat, 3, 32'h99, 32'h88, 5'd2);
        accept_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        issue_decode(5'd7, 5'd3, 5'd4, 8'h33);
        @(negedge clk);
        checks++;
        if (bus.rf_addr !== 5'd3) begin
            errors++;
            $display("FAIL mid_rs2_addr: got %0d want 3", bus.rf_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.dec_ready !== 1'b0 || bus.out_op_a !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b dec_ready=%b a=%h want 0/0/0",
                     bus.out_valid, bus.dec_ready, bus.out_op_a);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_idle: valid=%b dec_ready=%b want 0/1", bus.out_valid, bus.dec_ready);
        end
        issue_decode(5'd7, 5'd3, 5'd4, 8'h33);
        wait_out(lat);
        check_ops("mid_fresh", lat, 3, 32'h77, 32'h99, 5'd4);
        accept_out();
    endtask

`ifdef OPFETCH_IMM_EN
    task automatic test_imm();
        bus.dec_use_imm = 1'b1;
        bus.dec_imm     = 32'h40;
        issue_decode(5'd3, 5'd7, 5'd5, 8'h44);
        bus.dec_use_imm = 1'b0;
        checks++;
        if (bus.rf_addr !== 5'd3) begin
            errors++;
            $display("FAIL imm_rs1_addr: got %0d want 3", bus.rf_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.rf_addr !== 5'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL imm_no_rs2: addr=%0d valid=%b want 0/0", bus.rf_addr, bus.out_valid);
        end
        @(negedge clk);
        check_ops("imm", bus.out_valid === 1'b1 ? 2 : 0, 2, 32'h99, 32'h40, 5'd5);
        accept_out();
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
        rf_mem[0]    = 32'hDEAD;
        bus.rf_rdata = 32'h0;
        test_reset();
        test_basic();
        test_x0();
        test_wb_priority();
        test_hold_wb();
        test_reset_mid();
`ifdef OPFETCH_IMM_EN
        test_imm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch_seq.md
# operand_fetch_seq

Sequencer that sits upstream of the single-port processor register file (one 5-bit address, `ld_str` select, 32-bit store/load data). It accepts decoded instructions, reads rs1 and rs2 through the one shared port in consecutive cycles, and presents the operand pair to the execute stage with a valid/ready handshake. It also arbitrates result writeback into the same port.

## Interface
- `XLEN`, 32: data width
- `CTRL_W`, 8: opaque decode-control width, passed through unchanged
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `dec_valid` / `dec_ready`  in / out  1  decode handshake
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5  register addresses
- `dec_ctrl`  in  CTRL_W  control bundle
- `wb_valid` / `wb_ready`  in / out  1  writeback handshake
- `wb_addr`  in  5; `wb_data`  in  XLEN
- `rf_ld_str`  out  1  1 = load, 0 = store
- `rf_addr`  out  5; `rf_wdata`  out  XLEN; `rf_rdata`  in  XLEN (register file load data, registered in the file)
- `out_valid` / `out_ready`  out / in  1  execute handshake
- `out_op_a`, `out_op_b`  out  XLEN; `out_rd`  out  5; `out_ctrl`  out  CTRL_W

## Operation
- FSM states: IDLE, RS1, RS2, CAP, HOLD.
- IDLE:
  - If `wb_valid` is high, the write is taken and `dec_ready` is 0.
  - Otherwise `dec_ready` is 1. On a `dec_valid` handshake, rs1/rs2/rd/ctrl are latched and the FSM moves to RS1.
- RS1: drive `rf_ld_str`=1, `rf_addr`=rs1, then go to RS2.
- RS2: drive `rf_addr`=rs2 and capture `rf_rdata` into op_a, then go to CAP.
- CAP: capture `rf_rdata` into op_b, then go to HOLD.
- HOLD: `out_valid`=1 with all out_* stable. On `out_ready`, go to IDLE.
- Writeback:
  - `wb_ready` = (state is IDLE or HOLD) and not reset.
  - On handshake, drive `rf_ld_str`=0, `rf_addr`=`wb_addr`, `rf_wdata`=`wb_data` for that cycle. The store happens at that edge.
  - A write in HOLD does not alter captured operands.
- x0 handling: a read of address 0 is still issued (fixed latency), but the captured operand is forced to 0. A write to address 0 is handshaken (`wb_ready`=1), but `rf_ld_str` stays 1 (dropped).
- `rf_ld_str` is 1 in every cycle except accepted non-x0 writes. In non-write cycles, `rf_wdata` is 0.

## Timing
- Decode handshake at edge E0: `out_valid` rises after E0+3. The fastest accept-to-accept spacing is 5 cycles.
- Register-file read latency is one cycle, and this block depends on it.
- Handshakes complete on the rising `clk` edge with valid and ready both high. Valid must not depend on ready.
- In HOLD, `out_ready` and `wb_valid` in the same cycle complete both: the write occurs and the state goes to IDLE.
- Reset values: state IDLE, `out_valid` 0, all out_* 0, `rf_ld_str` 1, `rf_addr` 0, `rf_wdata` 0. `dec_ready` and `wb_ready` are 0 while reset is asserted.
- Reset mid-sequence abandons the instruction with no write issued. Register contents are untouched by this block.

## Configuration
- `OPFETCH_IMM_EN`: when defined, adds inputs `dec_use_imm` (1) and `dec_imm` (XLEN).
  - If `dec_use_imm` is latched high, RS2 is skipped: RS1 → CAP, `op_b` = `dec_imm`, and op_a is captured in CAP. Latency is 2 cycles to `out_valid`.
  - When not defined, those ports are absent and the RS2 read always occurs.

## Structure
- `opfetch_pkg`: state enum, `REG_AW`=5, `X0_ADDR`=5'd0, ld_str encodings `RF_LOAD`=1'b1 and `RF_STORE`=1'b0.
- Sub-module `opfetch_ctrl`: FSM, handshake readies and port mux select. The operand/capture registers stay in the top.

## Test plan
- Preload x3=0x11, x7=0x22 via wb. Decode rs1=3, rs2=7, rd=9 → `out_valid` 3 cycles later with op_a=0x11, op_b=0x22, rd=9.
- Decode rs1=0, rs2=5 (x5=0xABCD) → op_a=0, op_b=0xABCD. A wb to x0 of 0xFFFF leaves a later x0 read at 0 and `rf_ld_str` never 0.
- `wb_valid` and `dec_valid` together in IDLE → write first (`dec_ready`=0). Decode accepted the next cycle sees the new value.
- HOLD with `out_ready` low 4 cycles plus a wb to rs1 (x3=0x99) → outputs unchanged until handshake, then a re-read returns 0x99.
- Reset asserted in RS2 → `out_valid` stays 0, state IDLE, and a fresh decode completes normally.
- With `OPFETCH_IMM_EN` defined: `dec_use_imm`=1, imm=0x40, rs1=3 → `out_valid` 2 cycles later, op_b=0x40, no rs2 address driven.
